// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sample-RAM sequencer.
//   state_t : controller state encoding
//   bitrev  : reverse the low `width` bits of a value (bits above `width` must be zero)
//   LOG2N/N : default transform size, shared with the butterfly unit and twiddle ROM
package fft_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned LOG2N          = 5;
    localparam int unsigned N              = 1 << LOG2N;
    // Widest address bitrev() accepts.
    localparam int unsigned MAX_AW         = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRd,
        StBf,
        StWt,
        StWr,
        StUnload,
        StFlush
    } state_t;

    function automatic logic [MAX_AW-1:0] bitrev(input logic [MAX_AW-1:0] value,
                                                 input int unsigned width);
        logic [MAX_AW-1:0] rev;
        rev = {<<{value}};
        // Full-width reversal puts the wanted bits at the top; slide them down.
        return rev >> (MAX_AW - width);
    endfunction

endpackage

// File: rtl/fft_mem_ctrl_if.sv
// Signal bundle between the FFT sequencer and its environment (input stream,
// butterfly/twiddle datapath, sample RAM, result consumer).
//   master : sequencer side (drives RAM control/addresses, bf_go, results)
//   slave  : environment side (drives start, input stream, butterfly results)
interface fft_mem_ctrl_if
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = LOG2N
);
    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] bf_a;
    logic [DATA_WIDTH-1:0] bf_b;
    logic                  bf_go;
    logic [ADDR_WIDTH-2:0] tw_addr;
    logic                  ram_roW;
    logic                  ram_singlewrite;
    logic [ADDR_WIDTH-1:0] ram_A_addr;
    logic [ADDR_WIDTH-1:0] ram_B_addr;
    logic [DATA_WIDTH-1:0] ram_din_A;
    logic [DATA_WIDTH-1:0] ram_din_B;
    logic                  out_valid;
    logic [ADDR_WIDTH-1:0] out_index;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, in_valid, in_data, bf_a, bf_b,
        output in_ready, bf_go, tw_addr, ram_roW, ram_singlewrite, ram_A_addr, ram_B_addr,
               ram_din_A, ram_din_B, out_valid, out_index, busy, done
    );

    modport slave (
        output start, in_valid, in_data, bf_a, bf_b,
        input  in_ready, bf_go, tw_addr, ram_roW, ram_singlewrite, ram_A_addr, ram_B_addr,
               ram_din_A, ram_din_B, out_valid, out_index, busy, done
    );

endinterface

// File: rtl/fft_bf_addr.sv
// Radix-2 DIT butterfly address generator (purely combinational).
//   s  : stage index, 0..ADDR_WIDTH-1
//   k  : butterfly index within the stage, 0..N/2-1
//   a  : upper element address = (k >> s) * 2^(s+1) + (k mod 2^s)
//   b  : lower element address = a + 2^s
//   tw : twiddle ROM index     = (k mod 2^s) << (ADDR_WIDTH-1-s)
module fft_bf_addr
    import fft_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = LOG2N,
    parameter int unsigned STAGE_W    = $clog2(ADDR_WIDTH) + 1
) (
    input  logic [STAGE_W-1:0]    s,
    input  logic [ADDR_WIDTH-2:0] k,
    output logic [ADDR_WIDTH-1:0] a,
    output logic [ADDR_WIDTH-1:0] b,
    output logic [ADDR_WIDTH-2:0] tw
);
    localparam int unsigned KW = ADDR_WIDTH - 1;

    logic [ADDR_WIDTH-1:0] kx;
    logic [ADDR_WIDTH-1:0] half;
    logic [ADDR_WIDTH-1:0] grp;
    logic [ADDR_WIDTH-1:0] a_v;
    logic [KW-1:0]         pos;
    logic [STAGE_W-1:0]    tw_sh;

    always_comb begin
        kx    = {1'b0, k};
        half  = ADDR_WIDTH'(1) << s;
        grp   = kx >> s;
        pos   = k & KW'(half - ADDR_WIDTH'(1));
        // pos < half, so bit s of a_v is clear and a + half == a | half.
        a_v   = ((grp << s) << 1) | {1'b0, pos};
        tw_sh = STAGE_W'(ADDR_WIDTH - 1) - s;
        a     = a_v;
        b     = a_v | half;
        tw    = pos << tw_sh;
    end

endmodule

// File: rtl/fft_mem_ctrl.sv
// FFT sample-RAM sequencer: one complete in-place radix-2 DIT transform.
//   LOAD   : N input samples written through the single-write path in bit-reversed order
//   RD/BF/WT/WR : per butterfly, read the pair, hand it to the butterfly unit, wait
//            BF_LAT cycles, write the results back; LOG2N stages of N/2 butterflies
//   UNLOAD : natural-order read-out; out_valid/out_index follow one cycle later
//            (1-cycle RAM read latency), done pulses with the last result
// Ports: clk, rst (async, active-high) and the fft_mem_ctrl_if master bundle.
module fft_mem_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = LOG2N,
    parameter int unsigned BF_LAT     = 1
) (
    input logic            clk,
    input logic            rst,
    fft_mem_ctrl_if.master bus
);
    localparam int unsigned KW = ADDR_WIDTH - 1;
    localparam int unsigned SW = $clog2(ADDR_WIDTH) + 1;
    localparam int unsigned LW = $clog2(BF_LAT + 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [SW-1:0]         s_q, s_d;
    logic [KW-1:0]         k_q, k_d;
    logic [LW-1:0]         wcnt_q, wcnt_d;
    logic                  out_valid_q;
    logic [ADDR_WIDTH-1:0] out_index_q;

    logic [ADDR_WIDTH-1:0] pair_a;
    logic [ADDR_WIDTH-1:0] pair_b;
    logic [KW-1:0]         pair_tw;

    fft_bf_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STAGE_W    (SW)
    ) u_bf_addr (
        .s  (s_q),
        .k  (k_q),
        .a  (pair_a),
        .b  (pair_b),
        .tw (pair_tw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            s_q         <= '0;
            k_q         <= '0;
            wcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            k_q         <= k_d;
            wcnt_q      <= wcnt_d;
            // Results lag the unload read issue by the RAM read latency.
            out_valid_q <= (state_q == StUnload);
            out_index_q <= (state_q == StUnload) ? cnt_q : '0;
        end
    end

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        s_d                 = s_q;
        k_d                 = k_q;
        wcnt_d              = wcnt_q;
        bus.in_ready        = 1'b0;
        bus.bf_go           = 1'b0;
        bus.tw_addr         = '0;
        bus.ram_roW         = 1'b0;
        bus.ram_singlewrite = 1'b0;
        bus.ram_A_addr      = '0;
        bus.ram_B_addr      = '0;
        bus.ram_din_A       = '0;
        bus.ram_din_B       = '0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.ram_singlewrite = 1'b1;
                    bus.ram_A_addr      = ADDR_WIDTH'(bitrev(MAX_AW'(cnt_q), ADDR_WIDTH));
                    bus.ram_din_A       = bus.in_data;
                    cnt_d               = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = StRd;
                        s_d     = '0;
                        k_d     = '0;
                    end
                end
            end
            StRd: begin
                bus.ram_A_addr = pair_a;
                bus.ram_B_addr = pair_b;
                state_d        = StBf;
            end
            StBf: begin
                bus.ram_A_addr = pair_a;
                bus.ram_B_addr = pair_b;
                bus.bf_go      = 1'b1;
                bus.tw_addr    = pair_tw;
                if (BF_LAT > 1) begin
                    state_d = StWt;
                    wcnt_d  = LW'(1);
                end else begin
                    state_d = StWr;
                end
            end
            StWt: begin
                bus.ram_A_addr = pair_a;
                bus.ram_B_addr = pair_b;
                if (wcnt_q == LW'(BF_LAT - 1)) begin
                    state_d = StWr;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            StWr: begin
                bus.ram_roW    = 1'b1;
                bus.ram_A_addr = pair_a;
                bus.ram_B_addr = pair_b;
                bus.ram_din_A  = bus.bf_a;
                bus.ram_din_B  = bus.bf_b;
                if (k_q != '1) begin
                    k_d     = k_q + 1'b1;
                    state_d = StRd;
                end else if (s_q != SW'(ADDR_WIDTH - 1)) begin
                    s_d     = s_q + 1'b1;
                    k_d     = '0;
                    state_d = StRd;
                end else begin
                    s_d     = '0;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = StUnload;
                end
            end
            StUnload: begin
                bus.ram_A_addr = cnt_q;
                bus.ram_B_addr = cnt_q;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_index = out_index_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StFlush);

endmodule

// File: tb/tb_fft_mem_ctrl.sv
// Bench for fft_mem_ctrl: table of address-generator vectors, a RAM model with a
// loopback butterfly, write/result scoreboards, and hand-written timing/reset sequences.
module tb_fft_mem_ctrl;
    import fft_pkg::*;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int NP = N;
    localparam int HN = NP / 2;

    typedef struct {
        int s;
        int k;
        int a;
        int b;
        int tw;
    } ag_vec_t;

    typedef struct {
        int idx;
        int data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    fft_mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
    fft_mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus3 ();

    fft_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BF_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    fft_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BF_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    logic [3:0] ag_s;
    logic [3:0] ag_k;
    logic [4:0] ag_a;
    logic [4:0] ag_b;
    logic [3:0] ag_tw;

    fft_bf_addr #(.ADDR_WIDTH(AW)) u_ag (
        .s  (ag_s),
        .k  (ag_k),
        .a  (ag_a),
        .b  (ag_b),
        .tw (ag_tw)
    );

    // Dual-port RAM model (1-cycle read) plus loopback butterfly for dut1.
    logic [DW-1:0] mem [NP];
    logic [DW-1:0] dout_a, dout_b, bfa_q, bfb_q;
    always @(posedge clk) begin
        if (bus1.ram_singlewrite) mem[bus1.ram_A_addr] <= bus1.ram_din_A;
        if (bus1.ram_roW) begin
            mem[bus1.ram_A_addr] <= bus1.ram_din_A;
            mem[bus1.ram_B_addr] <= bus1.ram_din_B;
        end
        dout_a <= mem[bus1.ram_A_addr];
        dout_b <= mem[bus1.ram_B_addr];
        if (bus1.bf_go) begin
            bfa_q <= dout_a;
            bfb_q <= dout_b;
        end
    end
    assign bus1.bf_a = bfa_q;
    assign bus1.bf_b = bfb_q;

    // dut3 only gets timing checks: zero butterfly results, stream always available.
    assign bus3.bf_a     = '0;
    assign bus3.bf_b     = '0;
    assign bus3.in_valid = bus3.in_ready;
    assign bus3.in_data  = '0;

    logic any1, any3;
    assign any1 = |{bus1.in_ready, bus1.bf_go, bus1.tw_addr, bus1.ram_roW, bus1.ram_singlewrite,
                    bus1.ram_A_addr, bus1.ram_B_addr, bus1.ram_din_A, bus1.ram_din_B,
                    bus1.out_valid, bus1.out_index, bus1.busy, bus1.done};
    assign any3 = |{bus3.in_ready, bus3.bf_go, bus3.tw_addr, bus3.ram_roW, bus3.ram_singlewrite,
                    bus3.ram_A_addr, bus3.ram_B_addr, bus3.ram_din_A, bus3.ram_din_B,
                    bus3.out_valid, bus3.out_index, bus3.busy, bus3.done};

    function automatic int rev5(input int v);
        int r = 0;
        for (int i = 0; i < AW; i++) if (v[i]) r |= 1 << (AW - 1 - i);
        return r;
    endfunction

    // Butterfly n of the whole transform (stage = n / (N/2)).
    task automatic bf_model(input int n, output int a, output int b, output int tw);
        int s    = n / HN;
        int k    = n % HN;
        int half = 1 << s;
        int pos  = k & (half - 1);
        a  = (k >> s) * 2 * half + pos;
        b  = a + half;
        tw = pos << (AW - 1 - s);
    endtask

    exp_t wq[$];
    exp_t exp_q[$];
    int   xs[NP];
    int   ld_addr[8];
    int   nld1, nbf1, nw1, n_out1, done1_cyc, start_cyc;
    bit   done1_seen;
    int   nbf3, last_go3, done3_cyc;
    int   stage_go3[5];
    bit   done3_seen;

    always @(negedge clk) begin
        int   ea, eb, et;
        exp_t e;
        if (!rst) begin
            check("ctrl_exclusive", bus1.ram_roW & bus1.ram_singlewrite, 0);
            check("no_write_without_valid", bus1.ram_singlewrite & ~bus1.in_valid, 0);
            if (bus1.ram_singlewrite) begin
                if (nld1 < 8) ld_addr[nld1] = int'(bus1.ram_A_addr);
                nld1++;
                check("load_write_expected", wq.size() != 0, 1);
                if (wq.size() != 0) begin
                    e = wq.pop_front();
                    check("load_addr", bus1.ram_A_addr, e.idx);
                    check("load_data", bus1.ram_din_A, e.data);
                end
            end
            if (bus1.bf_go) begin
                bf_model(nbf1, ea, eb, et);
                check("bf_tw_addr", bus1.tw_addr, et);
                nbf1++;
            end
            if (bus1.ram_roW) begin
                bf_model(nw1, ea, eb, et);
                check("wr_addr_a", bus1.ram_A_addr, ea);
                check("wr_addr_b", bus1.ram_B_addr, eb);
                nw1++;
            end
            if (bus1.out_valid) begin
                n_out1++;
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_index", bus1.out_index, e.idx);
                    check("out_data", dout_a, e.data);
                end
            end
            if (bus1.done) begin
                done1_cyc  = cyc;
                done1_seen = 1'b1;
                check("done_with_last_out", {bus1.out_valid, bus1.out_index}, {1'b1, 5'd31});
            end
            if (bus3.bf_go) begin
                if (nbf3 % HN == 0 && nbf3 / HN < 5) stage_go3[nbf3 / HN] = cyc;
                last_go3 = cyc;
                nbf3++;
            end
            if (bus3.ram_roW) check("lat3_go_to_wr", cyc - last_go3, 3);
            if (bus3.done) begin
                done3_cyc  = cyc;
                done3_seen = 1'b1;
            end
        end
    end

    task automatic start_and_load(input bit gaps, input bit also3);
        exp_t e;
        nld1 = 0; nbf1 = 0; nw1 = 0; n_out1 = 0; done1_seen = 1'b0;
        if (also3) begin
            nbf3 = 0; done3_seen = 1'b0;
        end
        @(posedge clk); #1;
        bus1.start = 1'b1;
        bus3.start = also3;
        start_cyc  = cyc;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        bus3.start = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (gaps && (i % 5 == 3)) begin
                bus1.in_valid = 1'b0;
                bus1.in_data  = 16'hdead;
                @(posedge clk); #1;
            end
            bus1.in_valid = 1'b1;
            bus1.in_data  = DW'(xs[i]);
            e.idx = rev5(i);
            e.data = xs[i];
            wq.push_back(e);
            @(posedge clk); #1;
        end
        bus1.in_valid = 1'b0;
        for (int j = 0; j < NP; j++) begin
            e.idx  = j;
            e.data = xs[rev5(j)];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done1(input int budget);
        int n = 0;
        while (!done1_seen && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done1_within_budget", done1_seen, 1);
    endtask

    task automatic check_full_run(input string tag);
        wait_done1(800);
        check({tag, "_start_to_done"}, done1_cyc - start_cyc, 305);
        check({tag, "_out_count"}, n_out1, NP);
        check({tag, "_wr_count"}, nw1, AW * HN);
        check({tag, "_out_queue_drained"}, exp_q.size(), 0);
        check({tag, "_load_queue_drained"}, wq.size(), 0);
        @(negedge clk);
        check({tag, "_idle_after_done"}, bus1.busy, 0);
    endtask

    initial begin
        ag_vec_t ag_tab[7];
        int      n;
        ag_tab[0] = '{0, 0, 0, 1, 0};
        ag_tab[1] = '{2, 5, 9, 13, 4};
        ag_tab[2] = '{4, 15, 15, 31, 15};
        ag_tab[3] = '{1, 3, 5, 7, 8};
        ag_tab[4] = '{3, 10, 18, 26, 4};
        ag_tab[5] = '{0, 15, 30, 31, 0};
        ag_tab[6] = '{4, 0, 0, 16, 0};

        for (int i = 0; i < NP; i++) mem[i] = '0;
        rst           = 1'b1;
        bus1.start    = 1'b1;
        bus3.start    = 1'b1;
        bus1.in_valid = 1'b0;
        bus1.in_data  = '0;
        ag_s          = '0;
        ag_k          = '0;

        // Reset with start held high.
        repeat (2) @(negedge clk);
        check("rst_outputs_zero", any1, 0);
        check("rst_busy", bus1.busy, 0);
        check("rst_outputs_zero_lat3", any3, 0);

        // Address generator vectors.
        for (int i = 0; i < 7; i++) begin
            ag_s = 4'(ag_tab[i].s);
            ag_k = 4'(ag_tab[i].k);
            #1;
            check($sformatf("ag_a_s%0d_k%0d", ag_tab[i].s, ag_tab[i].k), ag_a, ag_tab[i].a);
            check($sformatf("ag_b_s%0d_k%0d", ag_tab[i].s, ag_tab[i].k), ag_b, ag_tab[i].b);
            check($sformatf("ag_tw_s%0d_k%0d", ag_tab[i].s, ag_tab[i].k), ag_tw, ag_tab[i].tw);
        end

        @(posedge clk); #1;
        rst        = 1'b0;
        bus1.start = 1'b0;
        bus3.start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_in_rst_ignored", bus1.busy, 0);
        check("start_in_rst_ignored_lat3", bus3.busy, 0);

        // Run A: in_data = index, continuous stream, both DUTs.
        for (int i = 0; i < NP; i++) xs[i] = i;
        start_and_load(1'b0, 1'b1);
        check_full_run("runA");
        check("load_cnt1_addr", ld_addr[1], 16);
        check("load_cnt6_addr", ld_addr[6], 12);
        n = 0;
        while (!done3_seen && n < 800) begin
            @(posedge clk);
            n++;
        end
        check("done3_within_budget", done3_seen, 1);
        check("lat3_start_to_done", done3_cyc - start_cyc, 465);
        check("lat3_stage0_len", stage_go3[1] - stage_go3[0], 80);
        check("lat3_stage1_len", stage_go3[2] - stage_go3[1], 80);
        check("lat3_stage3_len", stage_go3[4] - stage_go3[3], 80);

        // Run B: gapped load, then reset during a stage-2 write-back.
        for (int i = 0; i < NP; i++) xs[i] = int'($urandom_range(0, 65535));
        start_and_load(1'b1, 1'b0);
        check("gap_load_write_count", nld1, NP);
        n = 0;
        while (!(bus1.ram_roW && nw1 >= 36) && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        check("reached_stage2_wr", bus1.ram_roW, 1);
        rst = 1'b1;
        #1;
        check("midreset_outputs_zero", any1, 0);
        check("midreset_busy", bus1.busy, 0);
        exp_q.delete();
        wq.delete();
        @(posedge clk); #1;
        check("midreset_held_zero", any1, 0);
        rst = 1'b0;

        // Run C: fresh transform after the abort, random data.
        for (int i = 0; i < NP; i++) xs[i] = int'($urandom_range(0, 65535));
        start_and_load(1'b0, 1'b0);
        check_full_run("runC");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fft_mem_ctrl.md
# fft_mem_ctrl

Sequencing controller that drives the dual-port FFT sample RAM through one complete radix-2 DIT transform. It loads N input samples in bit-reversed order through the RAM's single-write path. It then runs LOG2N in-place butterfly stages, each butterfly being a pair-read, a hand-off to the external butterfly unit, and a pair-write-back. Finally it unloads the result in natural order. It sits between the input stream, the butterfly/twiddle datapath and the RAM's `roW`/`singlewrite`/address/data ports.

## Interface
- `DATA_WIDTH`, 16, sample word width; must match the RAM.
- `ADDR_WIDTH`, 5, RAM address width; N = 2**ADDR_WIDTH points, LOG2N = ADDR_WIDTH.
- `BF_LAT`, 1, butterfly unit latency in cycles from `bf_go` to valid `bf_a`/`bf_b`; must be ≥ 1.

Ports (clock and reset first). Reset is asynchronous and active-high.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a transform; sampled only in IDLE.
- `in_valid` in 1: input sample present.
- `in_data` in DATA_WIDTH: input sample.
- `in_ready` out 1: high in LOAD.
- `bf_a`, `bf_b` in DATA_WIDTH each: butterfly results for the upper and lower element.
- `bf_go` out 1: RAM read data is valid this cycle; butterfly unit captures it.
- `tw_addr` out ADDR_WIDTH-1: twiddle ROM index, valid with `bf_go`.
- `ram_roW`, `ram_singlewrite` out 1 each: RAM control.
- `ram_A_addr`, `ram_B_addr` out ADDR_WIDTH each: RAM addresses.
- `ram_din_A`, `ram_din_B` out DATA_WIDTH each: RAM write data.
- `out_valid` out 1: RAM `data_out_A` carries result `out_index` this cycle.
- `out_index` out ADDR_WIDTH: natural-order index of the current result.
- `busy` out 1: not IDLE.
- `done` out 1: one-cycle pulse with the last `out_valid`.

## Operation
- **Reset.** Every output is 0. State is IDLE and all counters are 0. RAM contents are untouched.
  - A reset mid-transform aborts immediately. No partial write is issued after `rst` is asserted.
- **IDLE.** `start` moves the block to LOAD. Otherwise `ram_roW` = `ram_singlewrite` = 0 and both addresses are 0.
- **LOAD.**
  - `in_ready` = 1.
  - On an `in_valid` cycle: `ram_singlewrite` = 1, `ram_A_addr` = bitrev(cnt), `ram_din_A` = `in_data`, and cnt increments.
  - `in_valid` low stalls the load; no write is issued that cycle.
  - After the sample with cnt = N-1, go to RD with stage s = 0 and butterfly index k = 0.
- **Butterfly address rule.** half = 1<<s, grp = k>>s, pos = k & (half-1).
  - A = grp·2·half + pos
  - B = A + half
  - tw_addr = pos << (LOG2N-1-s)
- **RD.** `ram_roW` = 0 with A and B on the address ports. Go to BF.
- **BF.** `bf_go` = 1 with `tw_addr`. Wait BF_LAT-1 further cycles in WT, then go to WR.
- **WR.** `ram_roW` = 1, same A/B, `ram_din_A` = `bf_a`, `ram_din_B` = `bf_b`. Then:
  - if k < N/2-1: k++ and go to RD;
  - else if s < LOG2N-1: s++, k = 0 and go to RD;
  - else go to UNLOAD with cnt = 0.
- **UNLOAD.** `ram_roW` = 0, `ram_A_addr` = `ram_B_addr` = cnt. After cnt = N-1, go to FLUSH.
- **FLUSH.** Final `out_valid` and `done` = 1, then go to IDLE.
- **Control exclusivity.** `ram_roW` and `ram_singlewrite` are never high together. Outside WR and LOAD writes, both are 0.
- **Ignored inputs.** `start` is ignored while busy. `in_valid` is ignored outside LOAD.

## Timing
- RAM read latency is 1 cycle: data requested in RD appears in BF, and data requested in UNLOAD appears one cycle later.
- `out_valid`/`out_index` are registered copies of the previous cycle's unload issue, so `out_index` lags `ram_A_addr` by one cycle.
- Each butterfly takes 2+BF_LAT cycles. A stage takes N/2·(2+BF_LAT) cycles.
- With a continuous input stream, start-to-done = 1 + N + LOG2N·N/2·(2+BF_LAT) + N cycles.
  - For defaults: 1 + 32 + 240 + 32 = 305 cycles.
- No read/write overlap: a pair is written back before the next pair is read, so in-place stages have no hazard.

## Structure
- `fft_pkg` holds:
  - the state encoding (IDLE, LOAD, RD, BF, WT, WR, UNLOAD, FLUSH);
  - a `bitrev(value, width)` function;
  - the LOG2N and N localparam derivations shared with the butterfly and twiddle ROM.
- Sub-module `fft_bf_addr`: combinational (s, k) → (A, B, tw_addr) per the rule above. It is unit-testable on its own.

## Test plan
- **Reset.** `rst` pulse → every output 0, `busy` 0. `start` asserted during `rst` is ignored.
- **Load order.** Continuous `in_valid` with `in_data` = index → write at cnt=1 goes to addr 16 and cnt=6 goes to addr 12. `in_valid` gaps insert no writes and do not advance cnt.
- **Address generator.**
  - s=0, k=0 → A=0, B=1, tw=0.
  - s=2, k=5 → A=9, B=13, tw=4.
  - s=4, k=15 → A=15, B=31, tw=15.
- **Full transform.** Loopback butterfly (`bf_a`/`bf_b` = captured inputs, BF_LAT=1) → `out_valid` with `out_index` 0..31 carries the bit-reversed input. `done` arrives 305 cycles after `start`.
- **BF_LAT=3.** WR occurs exactly 3 cycles after each `bf_go`. Per-stage length is 80 cycles.
- **Mid-stage reset.** `rst` asserted during a WR of stage 2 → same-cycle return to all-zero outputs. A new `start` runs cleanly.
